mm_engine_p: RTL
================

Name: mm_engine_p

Overview:
- Parametrised successor of the lab-4 matrix-multiply engine.
- Reads a 3-word header (R, K, C) from an external word-addressed memory, then computes C_out = A(R×K) · B(K×C) one output element at a time through a signed multiply-accumulate, writing each result back through the same memory port.
- New behaviour:
  - start/busy handshake instead of reset-triggered operation;
  - 1-cycle registered-read latency;
  - optional B-transpose mode;
  - saturating or truncating output;
  - sticky overflow flag;
  - zero-dimension early finish.

Parameters:
- DW, 20, signed element width of A and B; header word width.
- AW, 8, index/dimension width; dimensions are unsigned 0..2^AW-1.
- OW, 40, signed write_data width.
- SAT, 1, 1 = clamp result to OW signed range; 0 = keep low OW bits (wrap).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- tb  in  1  transpose-B mode; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- i  out  AW  row address of the current access.
- j  out  AW  column address of the current access.
- index  out  2  bank select: 0 = A, 1 = B, 2 = header/result-free; result writes use index=3.
- read  out  1  read strobe; read_data is valid in the following cycle.
- read_data  in  DW  memory data, signed (header words are taken as unsigned low AW bits).
- write  out  1  one-cycle write strobe for result element (i,j).
- write_data  out  OW  result value, qualified by write.
- finish  out  1  one-cycle done pulse.
- ovf  out  1  sticky flag: some result exceeded OW range; cleared on start.

Behaviour:
- Reset: state IDLE.
  - Outputs: i=j=0, index=0, read=write=finish=busy=ovf=0, write_data=0.
  - Accumulator and latched dimensions cleared.
  - Reset has priority over all other activity; asserting it mid-job aborts immediately with no further write.
- States: IDLE, HDR0..HDR3, CHK, RD_A, RD_B, MAC, WR, DONE.
- IDLE:
  - start=1 at a posedge → HDR0; latch tb; clear ovf.
  - start is ignored in every other state.
- Header phase:
  - HDR0/HDR1/HDR2 issue read, index=2, j=0, i=0/1/2.
  - HDR1/HDR2/HDR3 capture R/K/C respectively from read_data[AW-1:0].
- CHK:
  - if R, K or C is 0 → DONE with no writes;
  - else r=c=k=0 and acc=0 → RD_A.
- RD_A: read, index=0, i=r, j=k.
- RD_B:
  - read, index=1;
  - (i,j) = (k,c), or (c,k) when tb=1;
  - capture a = read_data.
- MAC:
  - acc += a·read_data;
  - full-precision signed product is 2·DW bits; accumulator is 2·DW+AW bits and never wraps;
  - k<K-1 → k+1, RD_A; else → WR.
- WR:
  - write=1, index=3, i=r, j=c;
  - write_data = sat_or_trunc(acc);
  - ovf set if acc lies outside the OW signed range (in both SAT modes);
  - acc cleared;
  - next element in row-major order (c increments, wraps to 0 and r increments);
  - after element (R-1,C-1) → DONE, else → RD_A.
- DONE: finish=1 for exactly one cycle, then IDLE.
- Outside the states listed above, read and write are low; read and write are never both high.
- busy is low in IDLE, high otherwise.
- Timing: start sampled at posedge P0 → finish is high in the cycle after posedge P0+5+R·C·(3K+1).
  - Zero-dimension job: finish in the cycle after P0+5.
- SAT=1: clamp to [-2^(OW-1), 2^(OW-1)-1]. SAT=0: low OW bits.
- i, j and index hold their last value when read and write are both low.

Test Plan:
- Basic multiply:
  - Header R=2,K=3,C=2; A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]].
  - Required: writes (0,0)=58, (0,1)=64, (1,0)=139, (1,1)=154 in that order; finish at P0+5+4·10=P0+45; ovf=0.
- Transpose mode:
  - tb=1, same A, B stored transposed.
  - Required: identical results; B reads use i=c, j=k.
- Signed values and saturation:
  - DW=20, OW=16, SAT=1, R=K=C=1, A=B=-524288.
  - Required: write_data=32767, ovf=1.
  - Repeat with SAT=0: write_data = low 16 bits of 2^38 = 0, ovf=1.
- Zero dimension:
  - Header K=0.
  - Required: no write pulses; finish one cycle after P0+5; busy high for exactly 6 cycles.
- Reset mid-job:
  - Assert reset during the 2nd element's MAC.
  - Required: next cycle all outputs at reset values; no further write; a new start then runs the full job correctly.
- Start while busy:
  - Pulse start during RD_B.
  - Required: ignored; results and finish timing unchanged; ovf from the previous job cleared only on the next accepted start.

Source files
------------

// File: rtl/mm_engine_p.sv
// Matrix-multiply engine: reads an (R,K,C) header, then A(RxK)*B(KxC) from a
// word-addressed memory with 1-cycle read latency, writing each result back.
module mm_engine_p #(
    parameter int DW  = 20,
    parameter int AW  = 8,
    parameter int OW  = 40,
    parameter int SAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          tb,
    output logic          busy,
    output logic [AW-1:0] i,
    output logic [AW-1:0] j,
    output logic [1:0]    index,
    output logic          read,
    input  logic [DW-1:0] read_data,
    output logic          write,
    output logic [OW-1:0] write_data,
    output logic          finish,
    output logic          ovf
);
    localparam int PW   = 2 * DW;
    localparam int ACCW = 2 * DW + AW;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_CHK,
        S_RD_A, S_RD_B, S_MAC, S_WR, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   tb_q, tb_d;
    logic                   ovf_q, ovf_d;
    logic [AW-1:0]          dim_r_q, dim_r_d, dim_k_q, dim_k_d, dim_c_q, dim_c_d;
    logic [AW-1:0]          r_q, r_d, c_q, c_d, k_q, k_d;
    logic signed [DW-1:0]   a_q, a_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [AW-1:0]          i_q, i_d, j_q, j_d;
    logic [1:0]             idx_q, idx_d;

    logic signed [PW-1:0]   prod;
    logic [ACCW-OW:0]       acc_hi;
    logic                   in_range;
    logic [OW-1:0]          res;

    // Result fits OW signed bits iff all bits from OW-1 upward agree.
    always_comb begin
        prod     = a_q * $signed(read_data);
        acc_hi   = acc_q[ACCW-1:OW-1];
        in_range = (&acc_hi) | (~|acc_hi);
        res      = acc_q[OW-1:0];
        if (SAT != 0 && !in_range)
            res = acc_q[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end

    always_comb begin
        state_d    = state_q;
        tb_d       = tb_q;
        ovf_d      = ovf_q;
        dim_r_d    = dim_r_q;
        dim_k_d    = dim_k_q;
        dim_c_d    = dim_c_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        a_d        = a_q;
        acc_d      = acc_q;
        i_d        = i_q;
        j_d        = j_q;
        idx_d      = idx_q;
        read       = 1'b0;
        write      = 1'b0;
        finish     = 1'b0;
        write_data = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR0;
                    tb_d    = tb;
                    ovf_d   = 1'b0;
                end
            end
            S_HDR0: begin
                read    = 1'b1;
                idx_d   = 2'd2;
                i_d     = AW'(0);
                j_d     = '0;
                state_d = S_HDR1;
            end
            S_HDR1: begin
                read    = 1'b1;
                idx_d   = 2'd2;
                i_d     = AW'(1);
                j_d     = '0;
                dim_r_d = read_data[AW-1:0];
                state_d = S_HDR2;
            end
            S_HDR2: begin
                read    = 1'b1;
                idx_d   = 2'd2;
                i_d     = AW'(2);
                j_d     = '0;
                dim_k_d = read_data[AW-1:0];
                state_d = S_HDR3;
            end
            S_HDR3: begin
                dim_c_d = read_data[AW-1:0];
                state_d = S_CHK;
            end
            S_CHK: begin
                if (dim_r_q == '0 || dim_k_q == '0 || dim_c_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                read    = 1'b1;
                idx_d   = 2'd0;
                i_d     = r_q;
                j_d     = k_q;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                read    = 1'b1;
                idx_d   = 2'd1;
                i_d     = tb_q ? c_q : k_q;
                j_d     = tb_q ? k_q : c_q;
                a_d     = $signed(read_data);
                state_d = S_MAC;
            end
            S_MAC: begin
                // Product is sign-extended into the wider accumulator, so it never wraps.
                acc_d = acc_q + {{AW{prod[PW-1]}}, prod};
                if (k_q == dim_k_q - 1'b1) begin
                    k_d     = '0;
                    state_d = S_WR;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_RD_A;
                end
            end
            S_WR: begin
                write      = 1'b1;
                idx_d      = 2'd3;
                i_d        = r_q;
                j_d        = c_q;
                write_data = res;
                acc_d      = '0;
                if (!in_range) ovf_d = 1'b1;
                if (c_q == dim_c_q - 1'b1) begin
                    c_d = '0;
                    if (r_q == dim_r_q - 1'b1) begin
                        state_d = S_DONE;
                    end else begin
                        r_d     = r_q + 1'b1;
                        state_d = S_RD_A;
                    end
                end else begin
                    c_d     = c_q + 1'b1;
                    state_d = S_RD_A;
                end
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tb_q    <= 1'b0;
            ovf_q   <= 1'b0;
            dim_r_q <= '0;
            dim_k_q <= '0;
            dim_c_q <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tb_q    <= tb_d;
            ovf_q   <= ovf_d;
            dim_r_q <= dim_r_d;
            dim_k_q <= dim_k_d;
            dim_c_q <= dim_c_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
        end
    end

    // Address outputs follow the current access and otherwise hold the last one.
    assign i     = i_d;
    assign j     = j_d;
    assign index = idx_d;
    assign busy  = (state_q != S_IDLE);
    assign ovf   = ovf_q;

endmodule
